turf_cmd_rx: RTL and testbench

TURF_CMD_RX -- requirements
Module: turf_cmd_rx

---
 rtl/turf_cmd_rx.sv | 125 ++++++++++++
 tb/tb_turf_cmd_rx.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/turf_cmd_rx.sv
// Serial command receiver for TURF trigger frames: start, buffer select, event ID,
// even parity and stop bit, decoded into a one-hot digitize request with error tracking.
//
// state  | meaning
// IDLE   | waiting for a start bit on the synchronized line
// SHIFT  | collecting buf, id, parity and stop bits, MSB first
// CHECK  | frame complete; validate and issue exactly one result pulse
module turf_cmd_rx #(
  parameter int ID_BITS     = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               cmd_i,
  input  logic [3:0]         buf_busy_i,
  output logic [3:0]         digitize_o,
  output logic [ID_BITS-1:0] event_id_o,
  output logic               cmd_valid_o,
  output logic               frame_err_o,
  output logic               overrun_o,
  output logic [15:0]        cmd_count_o,
  output logic [7:0]         err_count_o
);

  localparam int SR_BITS  = ID_BITS + 4;
  localparam int CNT_BITS = $clog2(SR_BITS + 1);
  localparam logic [CNT_BITS-1:0] LAST_BIT = CNT_BITS'(SR_BITS - 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_CHECK = 2'd2;

  logic [1:0]             rst_sync_q;
  logic                   rst_n;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   cmd_s;
  logic [1:0]             state;
  logic [CNT_BITS-1:0]    bitcnt;
  logic [SR_BITS-1:0]     sr;
  logic [1:0]             fr_buf;
  logic [ID_BITS-1:0]     fr_id;
  logic                   fr_bad;
  logic                   fr_busy;

  // Assert follows rst_i immediately; release is retimed so the FSM never sees a partial edge.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) rst_sync_q <= 2'b00;
    else        rst_sync_q <= {rst_sync_q[0], 1'b1};
  end

  assign rst_n = rst_sync_q[1];

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q[0] <= cmd_i;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign cmd_s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      bitcnt <= '0;
      sr     <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (cmd_s) begin
            state  <= ST_SHIFT;
            bitcnt <= '0;
          end
        end
        ST_SHIFT: begin
          sr     <= {sr[SR_BITS-2:0], cmd_s};
          bitcnt <= bitcnt + CNT_BITS'(1);
          if (bitcnt == LAST_BIT) state <= ST_CHECK;
        end
        ST_CHECK: state <= ST_IDLE;
        default:  state <= ST_IDLE;
      endcase
    end
  end

  // Shift register holds {buf, id, parity, stop} once the frame is complete.
  assign fr_buf  = sr[SR_BITS-1 -: 2];
  assign fr_id   = sr[ID_BITS+1:2];
  assign fr_bad  = sr[0] | (^sr[SR_BITS-1:1]);
  assign fr_busy = buf_busy_i[fr_buf];

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      digitize_o  <= 4'b0000;
      event_id_o  <= '0;
      cmd_valid_o <= 1'b0;
      frame_err_o <= 1'b0;
      overrun_o   <= 1'b0;
      cmd_count_o <= 16'h0000;
      err_count_o <= 8'h00;
    end else begin
      digitize_o  <= 4'b0000;
      cmd_valid_o <= 1'b0;
      frame_err_o <= 1'b0;
      overrun_o   <= 1'b0;
      if (state == ST_CHECK) begin
        if (fr_bad) begin
          frame_err_o <= 1'b1;
          if (err_count_o != 8'hFF) err_count_o <= err_count_o + 8'd1;
        end else if (fr_busy) begin
          overrun_o <= 1'b1;
          if (err_count_o != 8'hFF) err_count_o <= err_count_o + 8'd1;
        end else begin
          digitize_o  <= 4'b0001 << fr_buf;
          cmd_valid_o <= 1'b1;
          event_id_o  <= fr_id;
          cmd_count_o <= cmd_count_o + 16'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_turf_cmd_rx.sv
// Scoreboard bench for turf_cmd_rx: a frame-level model queues expected results,
// a monitor compares them whenever the receiver pulses.
module tb_turf_cmd_rx;

  localparam int ID_BITS     = 32;
  localparam int SYNC_STAGES = 2;
  localparam int FRAME_BITS  = ID_BITS + 5;

  logic               clk_i = 1'b0;
  logic               rst_i = 1'b1;
  logic               cmd_i = 1'b0;
  logic [3:0]         buf_busy_i = 4'b0000;
  logic [3:0]         digitize_o;
  logic [ID_BITS-1:0] event_id_o;
  logic               cmd_valid_o;
  logic               frame_err_o;
  logic               overrun_o;
  logic [15:0]        cmd_count_o;
  logic [7:0]         err_count_o;

  turf_cmd_rx #(.ID_BITS(ID_BITS), .SYNC_STAGES(SYNC_STAGES)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .cmd_i       (cmd_i),
    .buf_busy_i  (buf_busy_i),
    .digitize_o  (digitize_o),
    .event_id_o  (event_id_o),
    .cmd_valid_o (cmd_valid_o),
    .frame_err_o (frame_err_o),
    .overrun_o   (overrun_o),
    .cmd_count_o (cmd_count_o),
    .err_count_o (err_count_o)
  );

  always #15 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  int vectors = 0;
  int miscompares = 0;

  // kind: 0 accept, 1 frame error, 2 overrun
  typedef struct {
    int                 kind;
    logic [1:0]         bufn;
    logic [ID_BITS-1:0] id;
    logic [15:0]        cnt;
    logic [7:0]         err;
    int                 at;
  } exp_t;

  exp_t               sbq[$];
  exp_t               mon_e;
  logic [ID_BITS-1:0] m_id  = '0;
  logic [15:0]        m_cnt = '0;
  logic [7:0]         m_err = '0;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  task automatic send_frame(input logic [1:0] b, input logic [ID_BITS-1:0] id,
                            input bit bad_par, input bit bad_stop,
                            input logic [3:0] busy, input int gap);
    logic [FRAME_BITS-1:0] fr;
    logic                  par;
    int                    stop_at;
    exp_t                  e;
    par = (^{b, id}) ^ bad_par;
    fr  = {1'b1, b, id, par, bad_stop};
    stop_at = 0;
    for (int i = 0; i < FRAME_BITS; i++) begin
      @(negedge clk_i);
      cmd_i = fr[FRAME_BITS-1-i];
      // busy only matters in CHECK: scramble it mid-frame, settle it from the parity bit on
      if (i >= 2 && i <= ID_BITS + 2) buf_busy_i = 4'($urandom);
      else if (i == ID_BITS + 3)      buf_busy_i = busy;
      if (i == FRAME_BITS - 1) stop_at = cyc;
    end
    e.bufn = b;
    e.at   = stop_at + SYNC_STAGES + 2;
    if (bad_par || bad_stop) begin
      e.kind = 1;
      if (m_err != 8'hFF) m_err = m_err + 8'd1;
    end else if (busy[b]) begin
      e.kind = 2;
      if (m_err != 8'hFF) m_err = m_err + 8'd1;
    end else begin
      e.kind = 0;
      m_id   = id;
      m_cnt  = m_cnt + 16'd1;
    end
    e.id  = m_id;
    e.cnt = m_cnt;
    e.err = m_err;
    sbq.push_back(e);
    for (int g = 0; g <= gap; g++) begin
      @(negedge clk_i);
      cmd_i = 1'b0;
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (sbq.size() != 0 && n < 300) begin
      @(negedge clk_i);
      n++;
    end
    if (sbq.size() != 0) begin
      chk("drain_timeout", 64'(sbq.size()), 64'd0);
      sbq.delete();
    end
    repeat (3) @(negedge clk_i);
  endtask

  always @(negedge clk_i) begin
    if (rst_i) begin
      if (cmd_valid_o || frame_err_o || overrun_o) begin
        if (sbq.size() == 0) begin
          chk("unexpected_pulse", {61'd0, cmd_valid_o, frame_err_o, overrun_o}, 64'd0);
        end else begin
          mon_e = sbq.pop_front();
          chk("pulse_cycle", 64'(cyc), 64'(mon_e.at));
          chk("cmd_valid", 64'(cmd_valid_o), 64'(mon_e.kind == 0));
          chk("frame_err", 64'(frame_err_o), 64'(mon_e.kind == 1));
          chk("overrun", 64'(overrun_o), 64'(mon_e.kind == 2));
          chk("digitize", 64'(digitize_o),
              64'((mon_e.kind == 0) ? (4'b0001 << mon_e.bufn) : 4'b0000));
          chk("event_id", 64'(event_id_o), 64'(mon_e.id));
          chk("cmd_count", 64'(cmd_count_o), 64'(mon_e.cnt));
          chk("err_count", 64'(err_count_o), 64'(mon_e.err));
        end
      end else begin
        chk("digitize_quiet", 64'(digitize_o), 64'd0);
        if (sbq.size() != 0 && cyc > sbq[0].at) begin
          chk("missing_pulse", 64'(cyc), 64'(sbq[0].at));
          void'(sbq.pop_front());
        end
      end
    end
  end

  initial begin
    repeat (60000) @(posedge clk_i);
    $display("FAIL watchdog: cycle %0d reached, expected completion earlier", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [FRAME_BITS-1:0] abort_fr;
    logic [ID_BITS-1:0]    rid;
    int                    r;

    #1 rst_i = 1'b0;
    repeat (3) @(negedge clk_i);
    chk("rst_digitize", 64'(digitize_o), 64'd0);
    chk("rst_event_id", 64'(event_id_o), 64'd0);
    chk("rst_cmd_count", 64'(cmd_count_o), 64'd0);
    chk("rst_err_count", 64'(err_count_o), 64'd0);
    chk("rst_pulses", {61'd0, cmd_valid_o, frame_err_o, overrun_o}, 64'd0);
    rst_i = 1'b1;
    repeat (5) @(negedge clk_i);

    send_frame(2'd2, 32'h00C0FFEE, 1'b0, 1'b0, 4'b0000, 0);
    wait_idle();
    send_frame(2'd2, 32'h00C0FFEE, 1'b1, 1'b0, 4'b0000, 0);
    wait_idle();
    chk("event_id_after_err", 64'(event_id_o), 64'h00C0FFEE);
    send_frame(2'd1, 32'h12345678, 1'b0, 1'b0, 4'b0010, 0);
    wait_idle();
    chk("count_after_overrun", 64'(cmd_count_o), 64'd1);
    send_frame(2'd0, 32'd1, 1'b0, 1'b0, 4'b0000, 0);
    send_frame(2'd3, 32'd2, 1'b0, 1'b0, 4'b0000, 0);
    wait_idle();
    chk("count_back_to_back", 64'(cmd_count_o), 64'd3);

    for (int k = 0; k < 150; k++) begin
      rid = $urandom;
      r   = $urandom_range(9);
      send_frame(2'($urandom_range(3)), rid, (r < 2), (r == 2),
                 ($urandom_range(2) == 0) ? 4'($urandom) : 4'b0000, $urandom_range(3));
    end
    wait_idle();

    // abort a frame with reset at bit 10; nothing may come out of it
    abort_fr = {1'b1, 2'd1, 32'hA5A5A5A5, ^{2'd1, 32'hA5A5A5A5}, 1'b0};
    for (int i = 0; i <= 10; i++) begin
      @(negedge clk_i);
      cmd_i = abort_fr[FRAME_BITS-1-i];
      if (i == 10) begin
        rst_i = 1'b0;
        cmd_i = 1'b0;
      end
    end
    repeat (2) @(negedge clk_i);
    chk("midrst_cmd_count", 64'(cmd_count_o), 64'd0);
    chk("midrst_event_id", 64'(event_id_o), 64'd0);
    chk("midrst_err_count", 64'(err_count_o), 64'd0);
    m_id = '0;
    m_cnt = '0;
    m_err = '0;
    rst_i = 1'b1;
    repeat (6) @(negedge clk_i);
    send_frame(2'd3, 32'hDEADBEEF, 1'b0, 1'b0, 4'b0000, 0);
    wait_idle();
    chk("midrst_count_after", 64'(cmd_count_o), 64'd1);

    @(negedge clk_i);
    force dut.cmd_count_o = 16'hFFFF;
    @(negedge clk_i);
    release dut.cmd_count_o;
    m_cnt = 16'hFFFF;
    send_frame(2'd0, 32'h0000BEEF, 1'b0, 1'b0, 4'b0000, 0);
    wait_idle();
    chk("count_wrap", 64'(cmd_count_o), 64'd0);

    for (int k = 0; k < 300; k++)
      send_frame(2'($urandom_range(3)), $urandom, 1'b1, 1'b0, 4'b0000, 0);
    wait_idle();
    chk("err_saturate", 64'(err_count_o), 64'hFF);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
